// File: rtl/axis_stream_out.sv
// rtl/axis_stream_out.sv - AXI-Stream master for the Up-Sampling output, with SOF/EOL tagging and a 2-entry skid buffer
module axis_stream_out #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int UPSP_DATA_WIDTH = 32,
    parameter int DST_IMG_WIDTH   = 3840,
    parameter int DST_IMG_HEIGHT  = 2160
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       UPSTR,
    input  logic                       upsp_ac_wvalid,
    input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
    output logic                       ac_upsp_wready,
    output logic                       UPENDW,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_STRB_WIDTH-1:0] m_axis_tstrb,
    output logic [AXIS_STRB_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tid,
    output logic                       m_axis_tdest
);

    localparam int CW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int RW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(DST_IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state;
    logic [CW-1:0]              in_col;
    logic [RW-1:0]              in_row;
    logic                       in_done;
    logic [1:0]                 occ;
    logic [AXIS_DATA_WIDTH-1:0] head_data, tail_data;
    logic                       head_sof, head_eol, head_eof;
    logic                       tail_sof, tail_eol, tail_eof;

    logic                       accept, pop, start;
    logic                       in_sof, in_eol, in_eof;
    logic [AXIS_DATA_WIDTH-1:0] in_data;

    assign start  = (state == S_IDLE) & UPSTR;
    assign accept = upsp_ac_wvalid & ac_upsp_wready;
    assign pop    = m_axis_tvalid & m_axis_tready;
    assign in_sof = (in_col == '0) & (in_row == '0);
    assign in_eol = (in_col == COL_LAST);
    assign in_eof = in_eol & (in_row == ROW_LAST);
    assign in_data = AXIS_DATA_WIDTH'(upsp_ac_wdata);

    // Ready depends only on registered state so upstream never sees a path from tready.
    assign ac_upsp_wready = (state == S_RUN) & ~in_done & (occ != 2'd2);
    assign UPENDW         = (state == S_DONE);

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = head_data;
    assign m_axis_tuser  = head_sof & m_axis_tvalid;
    assign m_axis_tlast  = head_eol & m_axis_tvalid;
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;
    assign m_axis_tid    = 1'b0;
    assign m_axis_tdest  = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (UPSTR) state <= S_RUN;
                S_RUN:   if (pop && head_eof) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            in_done <= 1'b0;
        end else if (start) begin
            in_col  <= '0;
            in_row  <= '0;
            in_done <= 1'b0;
        end else if (accept) begin
            if (in_eof) in_done <= 1'b1;
            if (in_eol) begin
                in_col <= '0;
                in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
            end else begin
                in_col <= in_col + 1'b1;
            end
        end
    end

    // Head entry feeds the AXIS outputs directly; tail only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_sof  <= 1'b0;
            head_eol  <= 1'b0;
            head_eof  <= 1'b0;
            tail_data <= '0;
            tail_sof  <= 1'b0;
            tail_eol  <= 1'b0;
            tail_eof  <= 1'b0;
        end else begin
            case (occ)
                2'd0: begin
                    if (accept) begin
                        head_data <= in_data;
                        head_sof  <= in_sof;
                        head_eol  <= in_eol;
                        head_eof  <= in_eof;
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        head_data <= in_data;
                        head_sof  <= in_sof;
                        head_eol  <= in_eol;
                        head_eof  <= in_eof;
                    end else if (accept) begin
                        tail_data <= in_data;
                        tail_sof  <= in_sof;
                        tail_eol  <= in_eol;
                        tail_eof  <= in_eof;
                        occ       <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_sof  <= tail_sof;
                        head_eol  <= tail_eol;
                        head_eof  <= tail_eof;
                        occ       <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_out.sv
// tb/tb_axis_stream_out.sv - randomized and directed bench for axis_stream_out against a queue-based frame model
module tb_axis_stream_out;

    localparam int W = 4;
    localparam int H = 2;
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        UPSTR;
    logic        upsp_ac_wvalid;
    logic [31:0] upsp_ac_wdata;
    logic        ac_upsp_wready;
    logic        UPENDW;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tid;
    logic        m_axis_tdest;

    axis_stream_out #(
        .AXIS_DATA_WIDTH(32),
        .UPSP_DATA_WIDTH(32),
        .DST_IMG_WIDTH(W),
        .DST_IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .UPSTR(UPSTR),
        .upsp_ac_wvalid(upsp_ac_wvalid),
        .upsp_ac_wdata(upsp_ac_wdata),
        .ac_upsp_wready(ac_upsp_wready),
        .UPENDW(UPENDW),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pixels accepted but not yet sent, plus frame-level bookkeeping.
    logic [31:0] exp_q[$];
    int phase   = 0;   // 0 idle, 1 running, 2 end-of-frame pulse
    int n_in    = 0;
    int out_idx = 0;
    int frames  = 0;
    int sofs    = 0;
    int pulses  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            bit exp_valid, exp_ready, do_pop, do_push;
            int next_phase;
            exp_valid = (exp_q.size() != 0);
            exp_ready = (phase == 1) && (n_in < FRAME) && (exp_q.size() < 2);
            chk("tvalid", 32'(m_axis_tvalid), 32'(exp_valid));
            chk("wready", 32'(ac_upsp_wready), 32'(exp_ready));
            chk("upendw", 32'(UPENDW), 32'(phase == 2));
            if (UPENDW) pulses++;
            if (exp_valid) begin
                chk("tdata", m_axis_tdata, exp_q[0]);
                chk("tuser", 32'(m_axis_tuser), 32'(out_idx == 0));
                chk("tlast", 32'(m_axis_tlast), 32'((out_idx % W) == W - 1));
            end else begin
                chk("tuser_idle", 32'(m_axis_tuser), 32'd0);
                chk("tlast_idle", 32'(m_axis_tlast), 32'd0);
            end
            do_pop  = exp_valid && m_axis_tready;
            do_push = upsp_ac_wvalid && exp_ready;
            next_phase = phase;
            if (phase == 0 && UPSTR) begin
                next_phase = 1;
                n_in = 0;
            end else if (phase == 2) begin
                next_phase = 0;
            end
            if (do_pop) begin
                void'(exp_q.pop_front());
                if (out_idx == 0) sofs++;
                if (out_idx == FRAME - 1) begin
                    out_idx = 0;
                    frames++;
                    next_phase = 2;
                end else begin
                    out_idx++;
                end
            end
            if (do_push) begin
                exp_q.push_back(upsp_ac_wdata);
                n_in++;
            end
            phase = next_phase;
        end
    end

    task automatic step(input bit v, input bit r);
        bit acc;
        upsp_ac_wvalid = v;
        m_axis_tready  = r;
        @(negedge clk);
        acc = upsp_ac_wvalid && ac_upsp_wready;
        @(posedge clk);
        #1;
        if (acc) upsp_ac_wdata = upsp_ac_wdata + 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (phase != 0 && n < 50) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("idle_timeout", 32'(phase), 32'd0);
    endtask

    task automatic start_frame();
        UPSTR = 1'b1;
        step(1'b0, 1'b1);
        UPSTR = 1'b0;
    endtask

    initial begin
        int f0, n;
        rst_n = 1'b0;
        UPSTR = 1'b0;
        upsp_ac_wvalid = 1'b0;
        upsp_ac_wdata = 32'd1;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_wready", 32'(ac_upsp_wready), 32'd0);
        chk("rst_upendw", 32'(UPENDW), 32'd0);
        chk("tstrb", 32'(m_axis_tstrb), 32'hF);
        chk("tkeep", 32'(m_axis_tkeep), 32'hF);
        chk("tid_tdest", {30'd0, m_axis_tid, m_axis_tdest}, 32'd0);
        rst_n = 1'b1;

        // Idle gating: no UPSTR yet, so nothing may be accepted.
        repeat (3) step(1'b1, 1'b1);

        // Basic frame 0x01..0x08 back to back, then overrun guard.
        upsp_ac_wdata = 32'd1;
        start_frame();
        repeat (FRAME) step(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b1);
        chk("basic_frames", 32'(frames), 32'd1);
        chk("basic_pulses", 32'(pulses), 32'd1);
        wait_idle();

        // Backpressure mid-row.
        start_frame();
        repeat (2) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        chk("bp_full", 32'(exp_q.size()), 32'd2);
        n = 0;
        while (frames < 2 && n < 60) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk("bp_frames", 32'(frames), 32'd2);
        wait_idle();

        // Random stalls over three frames, UPSTR poked mid-run.
        f0 = frames;
        for (int f = 0; f < 3; f++) begin
            start_frame();
            n = 0;
            while (frames < f0 + f + 1 && n < 500) begin
                if (n == 3) UPSTR = 1'b1;
                if (n == 4) UPSTR = 1'b0;
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
                n++;
            end
            UPSTR = 1'b0;
            chk("rand_frame_done", 32'(frames), 32'(f0 + f + 1));
            wait_idle();
        end
        chk("rand_pulses", 32'(pulses), 32'(frames));
        chk("rand_sofs", 32'(sofs), 32'(frames));

        // Reset mid-frame after three beats.
        start_frame();
        repeat (4) step(1'b1, 1'b1);
        chk("pre_rst_sent", 32'(out_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        phase = 0;
        out_idx = 0;
        n_in = 0;
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_wready", 32'(ac_upsp_wready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frames;
        start_frame();
        n = 0;
        while (frames < f0 + 1 && n < 40) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk("post_rst_frame", 32'(frames), 32'(f0 + 1));
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
